sub_shift_nibbles: RTL
======================

# sub_shift_nibbles

Serial SubNibbles + ShiftRows stage of the 16-bit simplified-AES datapath, sitting directly upstream of the Mix_Column stage. It accepts one 16-bit state word on a load strobe and substitutes one nibble per clock through a single shared 4-bit S-box. It then applies ShiftRows and presents the result with a one-cycle done strobe. The `dn`/`d` pair wires straight into Mix_Column's `ld`/`c`. With `INVERSE=1` the same block serves the decrypt path: inverse S-box, and ShiftRows is its own inverse.

## Interface
- `INVERSE`, default 0: 0 uses the forward S-box; 1 uses the inverse S-box.
- `clk` input 1: rising-edge clock.
- `n_rst` input 1: reset, asynchronous, active-low.
- `ld` input 1: load strobe; samples `s` when accepted.
- `s` input 16: state word. Nibble n0 = `s[15:12]`, n1 = `[11:8]`, n2 = `[7:4]`, n3 = `[3:0]`. Column-major layout: row 0 = n0,n2; row 1 = n1,n3.
- `d` output 16: substituted and shifted state; holds until the next result.
- `dn` output 1: one-cycle pulse, high while a new `d` is first valid.
- `busy` output 1: high while a word is in flight (state SUB).

## Operation
- Forward S-box, indexed 0..F: 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- Inverse S-box, indexed 0..F: A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- ShiftRows swaps n1 and n3; n0 and n2 are unchanged. The full result is {S(n0), S(n3), S(n2), S(n1)}.
- FSM states: IDLE, SUB, DONE.
  - IDLE: if `ld`=1, load the working register with `s`, clear the 2-bit nibble counter, and go to SUB.
  - SUB: each cycle, replace working nibble[cnt] with S(nibble[cnt]) and increment cnt. When cnt=3, write the ShiftRows result of the fully substituted word into `d` and go to DONE.
  - DONE: `dn`=1 for exactly this cycle. If `ld`=1, accept a new word exactly as in IDLE (back-to-back) and go to SUB; otherwise go to IDLE.
- `ld` in SUB is ignored, with no queuing; `s` is not sampled there.
- Exactly one S-box instance exists; per-cycle nibble selection uses cnt.
- The counter wraps 3→0 only on transition out of SUB; it is never observed at a value above 3.

## Timing
- Reset (async, `n_rst`=0): state=IDLE, cnt=0, working register=0, `d`=16'h0000, `dn`=0, `busy`=0. Takes effect immediately, including mid-SUB; the partial word is discarded and no `dn` is issued.
- Reset release is synchronous to the first rising edge with `n_rst`=1. `ld` on that edge is accepted.
- Latency: if `ld` is accepted at edge E0, SUB occupies edges E1..E4 and `d`/`dn` update at E4. `dn` is high from E4 to E5, i.e. 4 cycles from accept to `dn`.
- Throughput: one word per 5 cycles with back-to-back `ld` held in DONE.
- `busy`=1 exactly while in SUB (4 cycles per word).
- `d` changes only on the edge entering DONE; it is stable at all other times.
- `s` need only be valid on the accepting edge.

## Structure
- Package `saes_pkg` holds:
  - `nibble_t` (logic [3:0]);
  - `SBOX` and `INV_SBOX` as 16-entry constant arrays of `nibble_t`;
  - the FSM enum `ssn_state_t` {IDLE, SUB, DONE};
  - the `shift_rows` function (16→16 bit, n1/n3 swap), shared with the key-path and decrypt stages.
- Sub-module `sbox_nibble`: combinational, parameter `INVERSE`, 4-bit in, 4-bit out, package-constant lookup. Instantiate it once inside `sub_shift_nibbles`.

## Test plan
- Reset: hold `n_rst`=0 for 10 cycles → `d`=0000, `dn`=0, `busy`=0. Pulse `n_rst` low mid-SUB → outputs clear immediately and no `dn` follows.
- Forward basic: `s`=16'h1234, one-cycle `ld` → `busy` high for 4 cycles, then `dn` pulses exactly 4 cycles after accept with `d`=16'h4DBA. `d` holds 4DBA for 20 more cycles.
- Forward edge values: 16'h0000 → 16'h9999; 16'hFFFF → 16'h7777.
- Back-to-back and ignored load:
  - hold `ld`=1 with 16'h1234 then 16'h0000 → `dn` pulses 5 cycles apart with 4DBA then 9999;
  - `ld` with 16'hFFFF during SUB → ignored, and no extra `dn`.
- Inverse (`INVERSE`=1): 16'h4DBA → 16'h1234; 16'h9999 → 16'h0000.
- Chain: drive `dn`/`d` into Mix_Column `ld`/`c` → Mix_Column asserts its done, and its output equals the golden S-AES MixColumns of 16'h4DBA.

Source files
------------

// File: rtl/saes_pkg.sv
// Shared types, S-box tables and ShiftRows for the 16-bit simplified-AES datapath.
package saes_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } ssn_state_t;

    localparam nibble_t SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    localparam nibble_t INV_SBOX [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
    };

    // Column-major 2x2 state: row 1 holds n1/n3, so a row rotate is a swap (self-inverse).
    function automatic logic [15:0] shift_rows(input logic [15:0] x);
        return {x[15:12], x[3:0], x[7:4], x[11:8]};
    endfunction

endpackage

// File: rtl/sbox_nibble.sv
// Combinational 4-bit S-box lookup; INVERSE selects the decrypt table.
module sbox_nibble
    import saes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [3:0] x,
    output logic [3:0] y
);

    assign y = INVERSE ? INV_SBOX[x] : SBOX[x];

endmodule

// File: rtl/sub_shift_nibbles.sv
// Serial SubNibbles (one nibble per clock through a shared S-box) followed by ShiftRows.
module sub_shift_nibbles
    import saes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        ld,
    input  logic [15:0] s,
    output logic [15:0] d,
    output logic        dn,
    output logic        busy
);

    ssn_state_t       state;
    ssn_state_t       state_next;
    logic             load;
    logic [1:0]       cnt;
    logic [1:0]       idx;
    nibble_t [3:0]    work;
    nibble_t [3:0]    work_next;
    nibble_t          sub_in;
    nibble_t          sub_out;

    // Nibble n0 lives in work[3], so counter value k addresses work[3-k].
    assign idx    = ~cnt;
    assign sub_in = work[idx];

    sbox_nibble #(.INVERSE(INVERSE)) u_sbox (
        .x(sub_in),
        .y(sub_out)
    );

    always_comb begin
        work_next      = work;
        work_next[idx] = sub_out;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    load       = 1'b1;
                    state_next = SUB;
                end
            end
            SUB: begin
                if (cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                load       = ld;
                state_next = ld ? SUB : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            work <= '0;
            cnt  <= 2'd0;
            d    <= 16'h0000;
        end else if (load) begin
            work <= s;
            cnt  <= 2'd0;
        end else if (state == SUB) begin
            work <= work_next;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) d <= shift_rows(work_next);
        end
    end

    assign dn   = (state == DONE);
    assign busy = (state == SUB);

endmodule
